// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/count widths and the normalizer FSM state encoding.
package alu_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } norm_state_t;

endpackage

// File: rtl/alu_norm_detect.sv
// Combinational termination and 8-bit fast-step eligibility for the normalizer.
// The fast step exists only when NORM_FAST_STEP_EN is defined.
module alu_norm_detect
   import alu_pkg::*;
(
   input  logic [XLEN-1:0]  work,
   input  logic [CNT_W-1:0] count,
   input  logic             mode,
   output logic             term,
   output logic             fast
);

   always_comb begin
      term = 1'b0;
      fast = 1'b0;
      if (mode) begin
         // Signed: stop once the top two bits differ; at most 31 redundant sign bits.
         term = (work[XLEN-1] != work[XLEN-2]) || (count == CNT_W'(31));
`ifdef NORM_FAST_STEP_EN
         fast = !term && ((work[XLEN-1:XLEN-9] == '0) || (work[XLEN-1:XLEN-9] == '1))
                && (count <= CNT_W'(23));
`endif
      end else begin
         term = work[XLEN-1] || (count == CNT_W'(32));
`ifdef NORM_FAST_STEP_EN
         fast = !term && (work[XLEN-1:XLEN-8] == '0) && (count <= CNT_W'(24));
`endif
      end
   end

endmodule

// File: rtl/alu_normalizer.sv
// Multi-cycle normalizer: returns the left-shift count that normalizes an operand and the shifted value.
// Optional 8-bit fast step enabled by defining NORM_FAST_STEP_EN.
module alu_normalizer
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_data,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [CNT_W-1:0] out_count,
   output norm_state_t      dbg_state
);

   // Handshake: a transfer happens on a rising clk edge where valid & ready are both high;
   // valid is never withdrawn and its payload never changes until that transfer.

   norm_state_t      state_q, state_d;
   logic [XLEN-1:0]  work_q, work_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic             term, fast;

   alu_norm_detect u_detect (
      .work  (work_q),
      .count (count_q),
      .mode  (mode_q),
      .term  (term),
      .fast  (fast)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         count_q <= count_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      count_d = count_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               mode_d  = in_signed;
               count_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (term) begin
               state_d = DONE;
            end else if (fast) begin
               work_d  = work_q << 8;
               count_d = count_q + CNT_W'(8);
            end else begin
               work_d  = work_q << 1;
               count_d = count_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs read zero outside DONE so the port values match the reset state.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_valid ? work_q : '0;
   assign out_count = out_valid ? count_q : '0;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_normalizer.sv
// Directed bench for alu_normalizer with hand-computed counts, data and latencies.
module tb_alu_normalizer;
   import alu_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [XLEN-1:0]  in_data = '0;
   logic             in_signed = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [XLEN-1:0]  out_data;
   logic [CNT_W-1:0] out_count;
   norm_state_t      dbg_state;

   int n_total = 0;
   int n_bad = 0;
   logic [37:0] exp_q[$];

   alu_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // drive one request at the negedge; returns just after the accept edge
   task automatic send(input logic [31:0] d, input logic s, input logic [5:0] cnt,
                       input logic [31:0] res);
      @(negedge clk);
      check("in_ready_before_req", {31'b0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = s;
      exp_q.push_back({cnt, res});
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
   endtask

   // called just after the accept edge; counts edges until out_valid is seen
   task automatic wait_result(input int exp_lat);
      int lat;
      logic [37:0] e;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!out_valid && lat < 200);
      check("latency", lat, exp_lat);
      e = exp_q.pop_front();
      check("out_count", {26'b0, out_count}, {26'b0, e[37:32]});
      check("out_data", out_data, e[31:0]);
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
      check("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run_vec(input logic [31:0] d, input logic s, input logic [5:0] cnt,
                          input logic [31:0] res, input int lat_slow, input int lat_fast);
      send(d, s, cnt, res);
`ifdef NORM_FAST_STEP_EN
      wait_result(lat_fast);
`else
      wait_result(lat_slow);
`endif
      handshake();
   endtask

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_count", {26'b0, out_count}, 32'd0);
      check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
      @(negedge clk);
      rst_n = 1'b1;

      // directed vectors: data, signed, count, result, slow latency, fast latency
      run_vec(32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 16, 9);
      run_vec(32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 33, 5);
      run_vec(32'hFFFF_F000, 1'b1, 6'd19, 32'h8000_0000, 20, 6);
      run_vec(32'h0000_0001, 1'b1, 6'd30, 32'h4000_0000, 31, 10);
      run_vec(32'hFFFF_FFFF, 1'b1, 6'd31, 32'h8000_0000, 32, 11);
      run_vec(32'h0000_0000, 1'b1, 6'd31, 32'h0000_0000, 32, 11);
      run_vec(32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1, 1);
      run_vec(32'h7FFF_FFFF, 1'b1, 6'd0,  32'h7FFF_FFFF, 1, 1);
      run_vec(32'h00F0_0000, 1'b0, 6'd8,  32'hF000_0000, 9, 2);

      // backpressure with a second request pending
      send(32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000);
`ifdef NORM_FAST_STEP_EN
      wait_result(9);
`else
      wait_result(16);
`endif
      exp_q.push_back({6'd23, 32'h8000_0000});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = 32'h0000_0100;
         in_signed = 1'b0;
         @(posedge clk);
         #1;
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_out_data", out_data, 32'h8000_0000);
         check("bp_out_count", {26'b0, out_count}, 32'd15);
      end
      handshake();
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bp_second_accepted", {31'b0, in_ready}, 32'd0);
`ifdef NORM_FAST_STEP_EN
      wait_result(10);
`else
      wait_result(24);
`endif
      handshake();

      // reset mid-SHIFT aborts the operation
      send(32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000);
      void'(exp_q.pop_back());
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_in_ready", {31'b0, in_ready}, 32'd1);
      check("abort_out_count", {26'b0, out_count}, 32'd0);
      check("abort_out_data", out_data, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_idle_after_release", {31'b0, in_ready}, 32'd1);
      check("abort_no_result", {31'b0, out_valid}, 32'd0);
      run_vec(32'hFFFF_F000, 1'b1, 6'd19, 32'h8000_0000, 20, 6);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
